// File: rtl/wb_regfile.sv
// wb_regfile: RV32I writeback mux, 32x32 register file and register-dump engine.
// Optional macro WB_BYPASS_EN makes the read ports write-first.
module wb_regfile #(
    parameter int NB_PC      = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NB_ADDR    = 5
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_regWrite,
    input  logic                  i_memToReg,
    input  logic                  i_jump,
    input  logic [NB_PC-1:0]      i_pc_next,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [DATA_WIDTH-1:0] i_alu,
    input  logic [NB_ADDR-1:0]    i_rd_addr,
    input  logic [NB_ADDR-1:0]    i_rs1_addr,
    input  logic [NB_ADDR-1:0]    i_rs2_addr,
    output logic [DATA_WIDTH-1:0] o_rs1_data,
    output logic [DATA_WIDTH-1:0] o_rs2_data,
    output logic [DATA_WIDTH-1:0] o_wb_data,
    input  logic                  i_dump_start,
    input  logic                  i_dump_ready,
    output logic                  o_dump_valid,
    output logic [NB_ADDR-1:0]    o_dump_addr,
    output logic [DATA_WIDTH-1:0] o_dump_data,
    output logic                  o_dump_done,
    output logic                  o_dump_busy
);
    localparam int NREG = 1 << NB_ADDR;
    typedef enum logic [1:0] {IDLE, DUMP, DONE} state_t;
    state_t                state_q, state_d;
    logic [NB_ADDR-1:0]    idx_q, idx_d, next_addr;
    logic [DATA_WIDTH-1:0] data_q, data_d, next_word;
    logic [DATA_WIDTH-1:0] regs_q [NREG];
    logic                  wr_en;
    assign o_wb_data = i_jump ? DATA_WIDTH'(i_pc_next) : (i_memToReg ? i_data : i_alu);
    assign wr_en     = i_regWrite && (i_rd_addr != '0);
`ifdef WB_BYPASS_EN
    assign o_rs1_data = (i_rs1_addr == '0) ? '0 :
                        (wr_en && i_rs1_addr == i_rd_addr) ? o_wb_data : regs_q[i_rs1_addr];
    assign o_rs2_data = (i_rs2_addr == '0) ? '0 :
                        (wr_en && i_rs2_addr == i_rd_addr) ? o_wb_data : regs_q[i_rs2_addr];
`else
    assign o_rs1_data = (i_rs1_addr == '0) ? '0 : regs_q[i_rs1_addr];
    assign o_rs2_data = (i_rs2_addr == '0) ? '0 : regs_q[i_rs2_addr];
`endif
    // The captured word must reflect a writeback landing on the same edge.
    assign next_addr = idx_q + 1'b1;
    assign next_word = (wr_en && i_rd_addr == next_addr) ? o_wb_data : regs_q[next_addr];
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        case (state_q)
            IDLE: if (i_dump_start) begin
                state_d = DUMP;
                idx_d   = '0;
                data_d  = '0;
            end
            DUMP: if (i_dump_ready) begin
                if (idx_q == '1) state_d = DONE;
                else begin
                    idx_d  = next_addr;
                    data_d = next_word;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            if (wr_en) regs_q[i_rd_addr] <= o_wb_data;
        end
    end
    assign o_dump_valid = (state_q == DUMP);
    assign o_dump_done  = (state_q == DONE);
    assign o_dump_busy  = (state_q != IDLE);
    assign o_dump_addr  = idx_q;
    assign o_dump_data  = data_q;
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed self-checking bench for wb_regfile.
module tb_wb_regfile;
    logic        clk = 0, i_rst = 1, i_regWrite = 0, i_memToReg = 0, i_jump = 0;
    logic [31:0] i_pc_next = 0, i_data = 0, i_alu = 0;
    logic [4:0]  i_rd_addr = 0, i_rs1_addr = 0, i_rs2_addr = 0;
    logic [31:0] o_rs1_data, o_rs2_data, o_wb_data, o_dump_data;
    logic        i_dump_start = 0, i_dump_ready = 0;
    logic        o_dump_valid, o_dump_done, o_dump_busy;
    logic [4:0]  o_dump_addr;
    int          errors = 0, checks = 0;

    wb_regfile dut (
        .clk(clk), .i_rst(i_rst), .i_regWrite(i_regWrite), .i_memToReg(i_memToReg),
        .i_jump(i_jump), .i_pc_next(i_pc_next), .i_data(i_data), .i_alu(i_alu),
        .i_rd_addr(i_rd_addr), .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
        .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data), .o_wb_data(o_wb_data),
        .i_dump_start(i_dump_start), .i_dump_ready(i_dump_ready),
        .o_dump_valid(o_dump_valid), .o_dump_addr(o_dump_addr), .o_dump_data(o_dump_data),
        .o_dump_done(o_dump_done), .o_dump_busy(o_dump_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] rd, input logic [31:0] v);
        i_regWrite = 1; i_memToReg = 0; i_jump = 0; i_rd_addr = rd; i_alu = v;
        tick();
        i_regWrite = 0;
    endtask

    task automatic test_reset();
        i_rst = 1;
        tick(); tick();
        i_rst = 0;
        for (int a = 0; a < 32; a++) begin
            i_rs1_addr = 5'(a); i_rs2_addr = 5'(31 - a); #1;
            checks++; if (o_rs1_data !== 32'h0) begin errors++; $display("FAIL reset_rs1[%0d] got=%h exp=0", a, o_rs1_data); end
            checks++; if (o_rs2_data !== 32'h0) begin errors++; $display("FAIL reset_rs2[%0d] got=%h exp=0", 31 - a, o_rs2_data); end
        end
        checks++; if (o_dump_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", o_dump_valid); end
        checks++; if (o_dump_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", o_dump_busy); end
        checks++; if (o_dump_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", o_dump_done); end
        checks++; if (o_dump_addr !== 5'd0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", o_dump_addr); end
        checks++; if (o_dump_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", o_dump_data); end
    endtask

    task automatic test_wb_mux();
        i_regWrite = 1; i_jump = 0; i_memToReg = 0; i_rd_addr = 5;
        i_alu = 32'hDEADBEEF; i_data = 32'h0BAD0BAD; i_pc_next = 32'h00000200; #1;
        checks++; if (o_wb_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wb_alu got=%h exp=deadbeef", o_wb_data); end
        tick();
        i_memToReg = 1; i_rd_addr = 6; i_data = 32'h12345678; i_alu = 32'h0BADF00D; #1;
        checks++; if (o_wb_data !== 32'h12345678) begin errors++; $display("FAIL wb_load got=%h exp=12345678", o_wb_data); end
        tick();
        i_jump = 1; i_rd_addr = 1; i_pc_next = 32'h00000104; #1;
        checks++; if (o_wb_data !== 32'h00000104) begin errors++; $display("FAIL wb_jump got=%h exp=00000104", o_wb_data); end
        tick();
        i_regWrite = 0; i_jump = 0; i_memToReg = 0;
        i_rs1_addr = 5; i_rs2_addr = 6; #1;
        checks++; if (o_rs1_data !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_x5 got=%h exp=deadbeef", o_rs1_data); end
        checks++; if (o_rs2_data !== 32'h12345678) begin errors++; $display("FAIL rd_x6 got=%h exp=12345678", o_rs2_data); end
        i_rs1_addr = 1; i_rs2_addr = 5; #1;
        checks++; if (o_rs1_data !== 32'h00000104) begin errors++; $display("FAIL rd_x1 got=%h exp=00000104", o_rs1_data); end
        checks++; if (o_rs2_data !== 32'hDEADBEEF) begin errors++; $display("FAIL rd2_x5 got=%h exp=deadbeef", o_rs2_data); end
    endtask

    task automatic test_x0();
        wr(5'd0, 32'hFFFFFFFF);
        i_rs1_addr = 0; i_rs2_addr = 0; #1;
        checks++; if (o_rs1_data !== 32'h0) begin errors++; $display("FAIL x0_rs1 got=%h exp=0", o_rs1_data); end
        checks++; if (o_rs2_data !== 32'h0) begin errors++; $display("FAIL x0_rs2 got=%h exp=0", o_rs2_data); end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_same;
`ifdef WB_BYPASS_EN
        exp_same = 32'hA5A5A5A5;
`else
        exp_same = 32'h0;
`endif
        i_regWrite = 1; i_memToReg = 0; i_jump = 0; i_rd_addr = 7; i_alu = 32'hA5A5A5A5;
        i_rs1_addr = 7; i_rs2_addr = 0; #1;
        checks++; if (o_rs1_data !== exp_same) begin errors++; $display("FAIL bypass_same got=%h exp=%h", o_rs1_data, exp_same); end
        checks++; if (o_rs2_data !== 32'h0) begin errors++; $display("FAIL bypass_x0 got=%h exp=0", o_rs2_data); end
        tick();
        i_regWrite = 0; #1;
        checks++; if (o_rs1_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL bypass_next got=%h exp=a5a5a5a5", o_rs1_data); end
    endtask

    task automatic test_dump_full();
        for (int n = 1; n < 32; n++) wr(5'(n), 32'(n) * 32'h11);
        i_dump_ready = 1; i_dump_start = 1;
        tick();
        i_dump_start = 0;
        for (int i = 0; i < 32; i++) begin
            if (i == 10) i_dump_start = 1;
            checks++; if (o_dump_valid !== 1'b1 || o_dump_addr !== 5'(i) || o_dump_data !== 32'(i) * 32'h11)
                begin errors++; $display("FAIL dump_word[%0d] got v=%b a=%0d d=%h exp v=1 a=%0d d=%h", i, o_dump_valid, o_dump_addr, o_dump_data, i, 32'(i) * 32'h11); end
            tick();
            i_dump_start = 0;
        end
        checks++; if (o_dump_done !== 1'b1 || o_dump_valid !== 1'b0 || o_dump_busy !== 1'b1)
            begin errors++; $display("FAIL dump_done got done=%b v=%b busy=%b exp 1 0 1", o_dump_done, o_dump_valid, o_dump_busy); end
        i_dump_start = 1;
        tick();
        i_dump_start = 0;
        checks++; if (o_dump_done !== 1'b0 || o_dump_busy !== 1'b0 || o_dump_valid !== 1'b0)
            begin errors++; $display("FAIL dump_idle got done=%b busy=%b v=%b exp 0 0 0", o_dump_done, o_dump_busy, o_dump_valid); end
        tick();
        checks++; if (o_dump_busy !== 1'b0) begin errors++; $display("FAIL start_in_done_ignored busy=%b exp=0", o_dump_busy); end
    endtask

    task automatic test_dump_stall_reset();
        i_dump_ready = 1; i_dump_start = 1;
        tick();
        i_dump_start = 0;
        repeat (4) tick();
        checks++; if (o_dump_addr !== 5'd4 || o_dump_data !== 32'h44)
            begin errors++; $display("FAIL stall_pre got a=%0d d=%h exp a=4 d=44", o_dump_addr, o_dump_data); end
        i_dump_ready = 0;
        i_regWrite = 1; i_rd_addr = 4; i_alu = 32'h99;
        for (int c = 0; c < 3; c++) begin
            tick();
            i_regWrite = 0;
            checks++; if (o_dump_valid !== 1'b1 || o_dump_addr !== 5'd4 || o_dump_data !== 32'h44)
                begin errors++; $display("FAIL stall_hold[%0d] got v=%b a=%0d d=%h exp v=1 a=4 d=44", c, o_dump_valid, o_dump_addr, o_dump_data); end
        end
        i_rs1_addr = 4; #1;
        checks++; if (o_rs1_data !== 32'h99) begin errors++; $display("FAIL stall_x4 got=%h exp=99", o_rs1_data); end
        i_dump_ready = 1; i_regWrite = 1; i_rd_addr = 5; i_alu = 32'h77;
        tick();
        i_regWrite = 0;
        checks++; if (o_dump_addr !== 5'd5 || o_dump_data !== 32'h77)
            begin errors++; $display("FAIL capture_same_edge got a=%0d d=%h exp a=5 d=77", o_dump_addr, o_dump_data); end
        repeat (5) tick();
        checks++; if (o_dump_addr !== 5'd10 || o_dump_data !== 32'hAA)
            begin errors++; $display("FAIL dump_at10 got a=%0d d=%h exp a=10 d=aa", o_dump_addr, o_dump_data); end
        i_rst = 1; i_regWrite = 1; i_rd_addr = 9; i_alu = 32'h1234;
        tick();
        i_rst = 0; i_regWrite = 0;
        checks++; if (o_dump_valid !== 1'b0 || o_dump_busy !== 1'b0 || o_dump_done !== 1'b0 || o_dump_addr !== 5'd0 || o_dump_data !== 32'h0)
            begin errors++; $display("FAIL abort got v=%b busy=%b done=%b a=%0d d=%h exp all 0", o_dump_valid, o_dump_busy, o_dump_done, o_dump_addr, o_dump_data); end
        tick();
        checks++; if (o_dump_done !== 1'b0) begin errors++; $display("FAIL abort_no_done got=%b exp=0", o_dump_done); end
        for (int a = 1; a < 32; a++) begin
            i_rs1_addr = 5'(a); #1;
            checks++; if (o_rs1_data !== 32'h0) begin errors++; $display("FAIL abort_clear[%0d] got=%h exp=0", a, o_rs1_data); end
        end
    endtask

    initial begin
        test_reset();
        test_wb_mux();
        test_x0();
        test_bypass();
        test_dump_full();
        test_dump_stall_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Writeback stage and architectural register file of the pipelined RV32I core. It sits downstream of the MEM/WB pipeline register and does three jobs:
- Selects the writeback value (PC+4, load data or ALU result) and commits it to the 32x32 register file.
- Serves the two ID-stage read ports.
- Runs a register-dump engine that streams all 32 registers to the debug unit over a valid/ready handshake.

Parameters:
NB_PC, 32, width of PC+4 writeback input
DATA_WIDTH, 32, register and data width
NB_ADDR, 5, register address width (32 entries)

Ports:
clk  input  1  clock, all state updates on rising edge
i_rst  input  1  synchronous active-high reset
i_regWrite  input  1  writeback enable from MEM/WB
i_memToReg  input  1  1: select load data, 0: select ALU result
i_jump  input  1  1: select PC+4 (overrides i_memToReg)
i_pc_next  input  NB_PC  PC+4 from MEM/WB
i_data  input  DATA_WIDTH  load data from MEM/WB
i_alu  input  DATA_WIDTH  ALU result from MEM/WB
i_rd_addr  input  NB_ADDR  destination register
i_rs1_addr  input  NB_ADDR  ID read port 1 address
i_rs2_addr  input  NB_ADDR  ID read port 2 address
o_rs1_data  output  DATA_WIDTH  read port 1 data (combinational)
o_rs2_data  output  DATA_WIDTH  read port 2 data (combinational)
o_wb_data  output  DATA_WIDTH  selected writeback value, for EX forwarding
i_dump_start  input  1  single-cycle request to dump all registers
i_dump_ready  input  1  debug unit accepts the current dump word
o_dump_valid  output  1  dump word valid
o_dump_addr  output  NB_ADDR  index of the current dump word
o_dump_data  output  DATA_WIDTH  current dump word
o_dump_done  output  1  one-cycle pulse after the last word is accepted
o_dump_busy  output  1  high in any state other than IDLE

Behaviour:
Writeback mux (combinational):
- o_wb_data = i_jump ? zero-extended/truncated i_pc_next : (i_memToReg ? i_data : i_alu).

Register write:
- At posedge, when i_regWrite=1 and i_rd_addr!=0, reg[i_rd_addr] <= o_wb_data.
- Writes to x0 are discarded; x0 always reads 0.

Reads:
- Asynchronous reads; address 0 returns 0.
- Same-cycle write/read collision is governed by WB_BYPASS_EN (see Optional Feature).

Reset (i_rst=1 at posedge):
- All 32 registers cleared to 0.
- FSM returns to IDLE; dump index cleared.
- o_dump_valid=0, o_dump_done=0, o_dump_busy=0, o_dump_addr=0, o_dump_data=0.
- Reset mid-dump aborts the dump; no done pulse is issued.
- Reset has priority over a simultaneous write or i_dump_start.

Dump FSM, states IDLE, DUMP, DONE:
- IDLE: when i_dump_start=1, go to DUMP. Index=0. Capture o_dump_data <= value of reg[0] (0).
- DUMP:
  - o_dump_valid=1.
  - o_dump_addr and o_dump_data stay stable until a handshake (valid & ready).
  - On handshake with index<31: index++ and capture reg[index+1] at that edge.
  - On handshake with index=31: go to DONE, clear o_dump_valid.
  - With ready held high, one word is transferred per cycle, so 32 words take 32 cycles.
- DONE: o_dump_done=1 for exactly one cycle, then IDLE.
- i_dump_start outside IDLE is ignored.
- Capture rule: the captured word is the value the register holds after any write at the same edge. If the writeback targets the register being captured, o_dump_data gets the new o_wb_data.
- A write to a register after its word has been captured does not change the held o_dump_data.
- Pipeline writebacks continue normally during a dump.

Optional Feature:
Macro WB_BYPASS_EN.
- Defined: write-first read ports. If i_regWrite=1, i_rd_addr!=0 and rsN_addr==i_rd_addr, o_rsN_data=o_wb_data in the same cycle.
- Undefined: read ports return the stored array value. The new value is visible the cycle after the write, so the hazard unit must cover the WB->ID case.

Test Plan:
- Reset, then read all addresses -> every o_rs1_data/o_rs2_data = 0; o_dump_valid=0, o_dump_busy=0.
- Write x5 with i_alu=0xDEADBEEF (memToReg=0, jump=0), then x6 with i_data=0x12345678 (memToReg=1), then x1 with i_jump=1 and i_pc_next=0x00000104 -> next cycle rs1=5 reads 0xDEADBEEF, rs2=6 reads 0x12345678, rs1=1 reads 0x00000104.
- Write x0 with 0xFFFFFFFF -> rs1=0 reads 0, and dump word 0 = 0.
- Bypass: same cycle, rd=7, i_alu=0xA5A5A5A5, rs1=7, x7 previously 0 -> with WB_BYPASS_EN rs1 reads 0xA5A5A5A5; without it rs1 reads 0, then 0xA5A5A5A5 the next cycle.
- Set xN=N*0x11 for N=1..31, pulse i_dump_start, hold ready=1 -> 32 consecutive words with addr 0..31 and data N*0x11 (addr 0 = 0); o_dump_done high for 1 cycle after addr 31; then IDLE.
- Dump with ready=0 for 3 cycles on addr 4 while x4 is overwritten with 0x99 -> held o_dump_data unchanged. Assert reset at addr 10 -> valid drops, no done pulse, all registers 0.
